// File: rtl/regfile_sc_if.sv
// regfile_sc_if
// Syscall queue drain bus between the register file's syscall FIFO and
// its consumer (console / testbench).
//   sc_valid  FIFO head is valid
//   sc_ready  consumer accepts the head this cycle
//   sc_code   0=INT, 1=CHAR, 2=EXIT
//   sc_data   argument carried by the head entry
// master: the FIFO side (regfile_sc). slave: the consumer side.
interface regfile_sc_if #(
  parameter int DATA_W = 32
) ();
  logic              sc_valid;
  logic              sc_ready;
  logic [1:0]        sc_code;
  logic [DATA_W-1:0] sc_data;

  modport master (
    output sc_valid,
    output sc_code,
    output sc_data,
    input  sc_ready
  );

  modport slave (
    input  sc_valid,
    input  sc_code,
    input  sc_data,
    output sc_ready
  );
endinterface

// File: rtl/regfile_sc.sv
// regfile_sc
// Decode-stage register file for the pipelined MIPS core with a queued
// syscall unit. Two registered read ports, one write port with a link
// register override, and a small FIFO of captured syscalls that a console
// drains over the sc bus. An EXIT syscall moves the block into a
// drain-then-halt sequence.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rs, rt                   read indices (data appears after the edge)
//   rd, write_data           write index and value
//   sig_reg_write, sig_jal   write enable, redirect write to RA_IDX
//   instr, instr_valid       instruction in decode (syscall = 32'h0000000C)
//   read_data_1/2            registered read data
//   stall                    FIFO full or not running; pipeline holds
//   halt                     core finished (sticky until rst)
//   sc                       syscall drain bus (regfile_sc_if.master)
//
// Build option: REGFILE_BYPASS_EN selects write-first reads (a read or
// syscall sample of the register being written this edge sees the new
// value). Without it, reads are read-first.
module regfile_sc #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int RA_IDX   = 31,
  parameter int V0_IDX   = 2,
  parameter int A0_IDX   = 4,
  parameter int SQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] write_data,
  input  logic              sig_reg_write,
  input  logic              sig_jal,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic              stall,
  output logic              halt,
  regfile_sc_if.master      sc
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam int PTR_W = $clog2(SQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [ADDR_W-1:0] RA = ADDR_W'(RA_IDX);
  localparam logic [ADDR_W-1:0] V0 = ADDR_W'(V0_IDX);
  localparam logic [ADDR_W-1:0] A0 = ADDR_W'(A0_IDX);

  localparam logic [1:0] SC_INT  = 2'd0;
  localparam logic [1:0] SC_CHAR = 2'd1;
  localparam logic [1:0] SC_EXIT = 2'd2;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t state, next_state;

  logic [DATA_W-1:0] regs [NREGS];
  logic [1:0]        code_mem [SQ_DEPTH];
  logic [DATA_W-1:0] data_mem [SQ_DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;

  logic              full, push, pop, exit_push;
  logic [1:0]        push_code;
  logic [DATA_W-1:0] push_data;
  logic [ADDR_W-1:0] wr_target;
  logic              wr_en;
  logic [DATA_W-1:0] rd1_next, rd2_next, v0_val, a0_val;

  // Index 0 always reads zero; with bypass a hit on the live write target
  // returns the incoming value instead of the stored one.
  function automatic logic [DATA_W-1:0] read_view(
    input logic [ADDR_W-1:0] idx,
    input logic [DATA_W-1:0] stored,
    input logic              hit,
    input logic [DATA_W-1:0] wdata
  );
    if (idx == '0)
      return '0;
    else if (hit)
      return wdata;
    else
      return stored;
  endfunction

  assign wr_target = sig_jal ? RA : rd;
  assign wr_en     = sig_reg_write && (state == RUN) && (wr_target != '0);

  assign rd1_next = read_view(rs, regs[rs], BYPASS && wr_en && (rs == wr_target), write_data);
  assign rd2_next = read_view(rt, regs[rt], BYPASS && wr_en && (rt == wr_target), write_data);
  assign v0_val   = read_view(V0, regs[V0], BYPASS && wr_en && (V0 == wr_target), write_data);
  assign a0_val   = read_view(A0, regs[A0], BYPASS && wr_en && (A0 == wr_target), write_data);

  assign full          = (count == CNT_W'(SQ_DEPTH));
  assign sc.sc_valid   = (count != '0);
  assign sc.sc_code    = code_mem[head];
  assign sc.sc_data    = data_mem[head];
  assign pop           = sc.sc_valid && sc.sc_ready;
  assign stall         = full || (state != RUN);
  assign halt          = (state == HALTED);

  // Register array and the two registered read ports. Index 0 is never
  // written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      read_data_1 <= '0;
      read_data_2 <= '0;
    end else begin
      if (wr_en) regs[wr_target] <= write_data;
      read_data_1 <= rd1_next;
      read_data_2 <= rd2_next;
    end
  end

  // Syscall decode: an unrecognised v0 code is silently dropped. Capture
  // is already gated by !full, so a blocked syscall is simply re-presented
  // by the stalled pipeline.
  always_comb begin
    push      = 1'b0;
    exit_push = 1'b0;
    push_code = SC_INT;
    push_data = '0;
    if (instr_valid && (instr == 32'h0000000C) && (state == RUN) && !full) begin
      if (v0_val == DATA_W'(1)) begin
        push      = 1'b1;
        push_code = SC_INT;
        push_data = a0_val;
      end else if (v0_val == DATA_W'(11)) begin
        push      = 1'b1;
        push_code = SC_CHAR;
        push_data = DATA_W'(a0_val[7:0]);
      end else if (v0_val == DATA_W'(10)) begin
        push      = 1'b1;
        exit_push = 1'b1;
        push_code = SC_EXIT;
      end
    end
  end

  // Syscall FIFO. Pointers wrap naturally because SQ_DEPTH is a power of
  // two; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SQ_DEPTH; i++) begin
        code_mem[i] <= '0;
        data_mem[i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        code_mem[tail] <= push_code;
        data_mem[tail] <= push_data;
        tail           <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Run-state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= next_state;
  end

  // No pushes happen outside RUN, so in DRAIN the EXIT entry is the last
  // one queued; popping an EXIT head therefore ends the drain.
  always_comb begin
    next_state = state;
    case (state)
      RUN:     if (exit_push) next_state = DRAIN;
      DRAIN:   if (pop && (sc.sc_code == SC_EXIT)) next_state = HALTED;
      HALTED:  next_state = HALTED;
      default: next_state = RUN;
    endcase
  end

endmodule

// File: tb/tb_regfile_sc.sv
// tb_regfile_sc
// Self-checking bench for regfile_sc. A behavioural model (register array
// plus a queue of syscall entries and a run/drain/halted mode) predicts
// every output; a negedge compare process checks the DUT against it each
// cycle, and directed scenarios pin the model with literal values.
// Build option REGFILE_BYPASS_EN is honoured by the model as well.
module tb_regfile_sc;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int SQ_DEPTH = 4;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] rs = '0, rt = '0, rd = '0;
  logic [DATA_W-1:0] write_data = '0;
  logic              sig_reg_write = 1'b0, sig_jal = 1'b0;
  logic [31:0]       instr = '0;
  logic              instr_valid = 1'b0;
  logic [DATA_W-1:0] read_data_1, read_data_2;
  logic              stall, halt;

  regfile_sc_if #(.DATA_W(DATA_W)) sc_bus ();

  regfile_sc #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RA_IDX(31), .V0_IDX(2), .A0_IDX(4), .SQ_DEPTH(SQ_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd), .write_data(write_data),
    .sig_reg_write(sig_reg_write), .sig_jal(sig_jal), .instr(instr),
    .instr_valid(instr_valid), .read_data_1(read_data_1), .read_data_2(read_data_2),
    .stall(stall), .halt(halt), .sc(sc_bus)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  typedef struct packed {
    logic [1:0]  code;
    logic [31:0] data;
  } entry_t;

  logic [31:0] m_regs [32];
  entry_t      m_q [$];
  int          m_mode;          // 0 running, 1 draining, 2 halted
  logic [31:0] exp_rd1, exp_rd2;
  bit          model_live = 1'b0;
  int          errors = 0;
  int          checks = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] m_view(input int idx, input bit wr, input int tgt, input logic [31:0] wd);
    if (idx == 0) return 32'h0;
    if (BYPASS && wr && idx == tgt) return wd;
    return m_regs[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_q.delete();
    m_mode  = 0;
    exp_rd1 = 32'h0;
    exp_rd2 = 32'h0;
  endtask

  // Advance the model across the coming posedge using the driven inputs.
  task automatic model_step();
    int          tgt;
    bit          running, wr, full, pop, push, is_exit;
    logic [31:0] v0, a0;
    entry_t      item, popped;
    tgt     = sig_jal ? 31 : int'(rd);
    running = (m_mode == 0);
    wr      = sig_reg_write && running && (tgt != 0);
    full    = (m_q.size() == SQ_DEPTH);
    pop     = (m_q.size() != 0) && sc_bus.sc_ready;
    exp_rd1 = m_view(int'(rs), wr, tgt, write_data);
    exp_rd2 = m_view(int'(rt), wr, tgt, write_data);
    push    = 1'b0;
    is_exit = 1'b0;
    item    = '0;
    if (instr_valid && instr == 32'h0000000C && running && !full) begin
      v0 = m_view(2, wr, tgt, write_data);
      a0 = m_view(4, wr, tgt, write_data);
      if (v0 == 1) begin
        push = 1'b1; item.code = 2'd0; item.data = a0;
      end else if (v0 == 11) begin
        push = 1'b1; item.code = 2'd1; item.data = {24'h0, a0[7:0]};
      end else if (v0 == 10) begin
        push = 1'b1; is_exit = 1'b1; item.code = 2'd2; item.data = 32'h0;
      end
    end
    if (pop) begin
      popped = m_q.pop_front();
      if (m_mode == 1 && popped.code == 2'd2) m_mode = 2;
    end
    if (push) begin
      m_q.push_back(item);
      if (is_exit) m_mode = 1;
    end
    if (wr) m_regs[tgt] = write_data;
  endtask

  // Compare process: every cycle out of reset, DUT outputs versus model.
  always @(negedge clk) begin
    if (model_live && !rst) begin
      checkOutput("read_data_1", read_data_1, exp_rd1);
      checkOutput("read_data_2", read_data_2, exp_rd2);
      checkOutput("stall", {31'h0, stall}, {31'h0, (m_q.size() == SQ_DEPTH) || (m_mode != 0)});
      checkOutput("halt", {31'h0, halt}, {31'h0, m_mode == 2});
      checkOutput("sc_valid", {31'h0, sc_bus.sc_valid}, {31'h0, m_q.size() != 0});
      if (m_q.size() != 0) begin
        checkOutput("sc_code", {30'h0, sc_bus.sc_code}, {30'h0, m_q[0].code});
        checkOutput("sc_data", sc_bus.sc_data, m_q[0].data);
      end
    end
  end

  // Drive one cycle of inputs just after a negedge and step the model.
  task automatic applyStimulus(
    input logic [4:0] a_rs, input logic [4:0] a_rt, input logic [4:0] a_rd,
    input logic [31:0] a_wd, input logic a_we, input logic a_jal,
    input logic a_iv, input logic [31:0] a_instr, input logic a_ready
  );
    @(negedge clk);
    #1;
    rs = a_rs; rt = a_rt; rd = a_rd; write_data = a_wd;
    sig_reg_write = a_we; sig_jal = a_jal;
    instr_valid = a_iv; instr = a_instr; sc_bus.sc_ready = a_ready;
    model_step();
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d, input logic ready);
    applyStimulus(5'd0, 5'd0, r, d, 1'b1, 1'b0, 1'b0, 32'h0, ready);
  endtask

  task automatic sys(input logic ready);
    applyStimulus(5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000000C, ready);
  endtask

  task automatic idle(input logic ready);
    applyStimulus(5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, ready);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // Literal expectation checked against both the DUT and the model.
  task automatic pin(input string name, input logic [31:0] dut_val, input logic [31:0] model_val, input logic [31:0] lit);
    checkOutput(name, dut_val, lit);
    checkOutput({name, "_model"}, model_val, lit);
  endtask

  task automatic doReset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    rs = '0; rt = '0; rd = '0; write_data = '0; sig_reg_write = 1'b0;
    sig_jal = 1'b0; instr_valid = 1'b0; instr = '0; sc_bus.sc_ready = 1'b0;
    model_reset();
    model_live = 1'b1;
    #1;
    checkOutput("reset_rd1", read_data_1, 32'h0);
    checkOutput("reset_rd2", read_data_2, 32'h0);
    checkOutput("reset_stall", {31'h0, stall}, 32'h0);
    checkOutput("reset_halt", {31'h0, halt}, 32'h0);
    checkOutput("reset_sc_valid", {31'h0, sc_bus.sc_valid}, 32'h0);
    checkOutput("reset_sc_code", {30'h0, sc_bus.sc_code}, 32'h0);
    checkOutput("reset_sc_data", sc_bus.sc_data, 32'h0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    model_step();
  endtask

  logic [31:0] v0_table [6];
  int          halted_run;

  initial begin
    sc_bus.sc_ready = 1'b0;
    v0_table[0] = 32'd1;  v0_table[1] = 32'd11; v0_table[2] = 32'd10;
    v0_table[3] = 32'd1;  v0_table[4] = 32'd11; v0_table[5] = 32'd3;

    doReset();

    // Basic write then read, and writes to index 0 are dropped
    wr(5'd5, 32'hDEADBEEF, 1'b0);
    applyStimulus(5'd5, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    settle();
    pin("read_r5", read_data_1, exp_rd1, 32'hDEADBEEF);
    applyStimulus(5'd0, 5'd0, 5'd0, 32'h1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    settle();
    pin("read_r0", read_data_1, exp_rd1, 32'h0);

    // Same-edge write and read of r7
    applyStimulus(5'd0, 5'd7, 5'd7, 32'h55, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    settle();
    pin("same_edge_r7", read_data_2, exp_rd2, BYPASS ? 32'h55 : 32'h0);

    // Link register override
    applyStimulus(5'd0, 5'd0, 5'd3, 32'h400, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(5'd31, 5'd3, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    settle();
    pin("jal_r31", read_data_1, exp_rd1, 32'h400);
    pin("jal_r3", read_data_2, exp_rd2, 32'h0);

    // CHAR and INT syscalls
    wr(5'd2, 32'd11, 1'b0);
    wr(5'd4, 32'h141, 1'b0);
    sys(1'b1);
    settle();
    pin("char_valid", {31'h0, sc_bus.sc_valid}, {31'h0, m_q.size() != 0}, 32'h1);
    pin("char_code", {30'h0, sc_bus.sc_code}, {30'h0, m_q[0].code}, 32'h1);
    pin("char_data", sc_bus.sc_data, m_q[0].data, 32'h41);
    wr(5'd2, 32'd1, 1'b1);
    wr(5'd4, 32'hFFFFFFF9, 1'b0);
    sys(1'b0);
    settle();
    pin("int_code", {30'h0, sc_bus.sc_code}, {30'h0, m_q[0].code}, 32'h0);
    pin("int_data", sc_bus.sc_data, m_q[0].data, 32'hFFFFFFF9);
    idle(1'b1);

    // Fill the FIFO past capacity with the consumer stalled
    for (int i = 0; i < 5; i++) begin
      wr(5'd4, 32'd100 + 32'(i), 1'b0);
      sys(1'b0);
      settle();
      if (i == 3) pin("full_stall", {31'h0, stall}, {31'h0, m_q.size() == SQ_DEPTH}, 32'h1);
      if (i == 4) pin("full_head", sc_bus.sc_data, m_q[0].data, 32'd100);
    end
    sys(1'b1);
    settle();
    pin("full_pop_blocks_push", sc_bus.sc_data, m_q[0].data, 32'd101);
    sys(1'b0);
    for (int j = 1; j < 4; j++) begin
      idle(1'b1);
      settle();
      pin("wrap_order", sc_bus.sc_data, m_q[0].data, 32'd101 + 32'(j));
    end
    idle(1'b1);
    settle();
    pin("drained_valid", {31'h0, sc_bus.sc_valid}, {31'h0, m_q.size() != 0}, 32'h0);

    // EXIT behind two pending entries
    wr(5'd2, 32'd1, 1'b0);
    wr(5'd4, 32'd200, 1'b0);
    sys(1'b0);
    wr(5'd4, 32'd201, 1'b0);
    sys(1'b0);
    wr(5'd2, 32'd10, 1'b0);
    sys(1'b0);
    settle();
    pin("drain_stall", {31'h0, stall}, {31'h0, m_mode != 0}, 32'h1);
    applyStimulus(5'd0, 5'd0, 5'd9, 32'h99, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(5'd9, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    settle();
    pin("drain_write_ignored", read_data_1, exp_rd1, 32'h0);
    pin("halt_after_pop1", {31'h0, halt}, {31'h0, m_mode == 2}, 32'h0);
    idle(1'b1);
    settle();
    pin("halt_after_pop2", {31'h0, halt}, {31'h0, m_mode == 2}, 32'h0);
    idle(1'b1);
    settle();
    pin("halt_after_pop3", {31'h0, halt}, {31'h0, m_mode == 2}, 32'h1);
    idle(1'b1);
    idle(1'b0);

    // Reset while draining discards the queue
    doReset();
    wr(5'd2, 32'd10, 1'b0);
    sys(1'b0);
    wr(5'd4, 32'd5, 1'b0);
    settle();
    pin("exit_stall", {31'h0, stall}, {31'h0, m_mode != 0}, 32'h1);
    doReset();

    // Randomised traffic against the model
    halted_run = 0;
    for (int n = 0; n < 2000; n++) begin
      if (m_mode == 2) halted_run++;
      else             halted_run = 0;
      if (halted_run > 3 || $urandom_range(0, 199) == 0) begin
        doReset();
        halted_run = 0;
      end else begin
        logic [4:0]  r_rs, r_rt, r_rd;
        logic [31:0] r_wd, r_instr;
        logic        r_iv;
        r_rs = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
        r_rt = 5'($urandom_range(0, 7));
        r_rd = 5'($urandom_range(0, 7));
        r_wd = (r_rd == 5'd2) ? v0_table[$urandom_range(0, 5)] : $urandom;
        r_iv = ($urandom_range(0, 2) == 0);
        r_instr = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0000000C;
        applyStimulus(r_rs, r_rt, r_rd, r_wd, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 9) == 0), r_iv, r_instr,
                      1'($urandom_range(0, 1)));
      end
    end
    idle(1'b0);
    @(negedge clk);
    #2;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sc.md
# regfile_sc

Parametrised register file with a queued syscall unit for the pipelined MIPS core, sitting in the decode stage. It provides two registered read ports, one write port with link-register override, and optional same-cycle write-to-read bypass. Syscalls are captured into a small FIFO drained by the testbench/console through a valid/ready handshake. An exit syscall drives a drain-then-halt state machine instead of ending simulation directly.

## Interface
- DATA_W, 32, register and data width
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- RA_IDX, 31, link register written when sig_jal
- V0_IDX, 2, syscall code register
- A0_IDX, 4, syscall argument register
- SQ_DEPTH, 4, syscall FIFO entries (power of two, ≥2)
- clk  in  1  single clock; all state changes on posedge
- rst  in  1  asynchronous, active-high reset
- rs, rt  in  ADDR_W  read indices
- rd  in  ADDR_W  write index
- write_data  in  DATA_W  write value
- sig_reg_write  in  1  write enable
- sig_jal  in  1  redirect write to RA_IDX
- instr  in  32  instruction in decode
- instr_valid  in  1  instr is live this cycle
- read_data_1, read_data_2  out  DATA_W  registered read data
- stall  out  1  FIFO full or not RUN; pipeline must hold
- sc_valid  out  1  FIFO head valid
- sc_ready  in  1  consumer accepts head
- sc_code  out  2  0=INT, 1=CHAR, 2=EXIT
- sc_data  out  DATA_W  argument of head entry
- halt  out  1  sticky, core finished

## Operation
- Storage: 2**ADDR_W × DATA_W; index 0 reads 0 and ignores writes.
- Write at posedge when sig_reg_write and state==RUN: target = RA_IDX if sig_jal else rd; rd==0 without jal → no write.
- Read at posedge: read_data_n ← regs[idx] (bypassed value per Configuration).
- Syscall detect: instr_valid && instr==32'h0000000C && state==RUN && !full. Effective v0/a0 sampled at that edge:
  - v0==1 → push {INT, a0}
  - v0==11 → push {CHAR, zero-extended a0[7:0]}
  - v0==10 → push {EXIT, 0}; state → DRAIN
  - other v0 → no push, no error
- Syscall while full: no push; stall is high, so the pipeline re-presents the instruction.
- FIFO: pop when sc_valid && sc_ready. Push and pop in the same cycle are both performed (count unchanged). Push is still blocked when full, even if a pop occurs that cycle.
- FSM RUN → DRAIN on EXIT push; DRAIN → HALTED on the cycle the EXIT entry pops. HALTED is terminal until rst.
- In DRAIN/HALTED, register writes and syscall pushes are ignored; reads continue.
- stall = full || state!=RUN (combinational from registered state).
- halt = (state==HALTED), registered.

## Timing
- Reset (async assert, sync-to-clk deassert is not required) clears to 0: all regs, read_data_1/2, FIFO pointers/count, sc_valid, sc_code, sc_data, halt, stall. State → RUN.
- Read latency: 1 cycle (indices at edge N → data valid after edge N).
- Syscall → sc_valid: entry visible after the capturing edge.
- EXIT → halt: halt rises the edge after the EXIT entry's pop handshake.
- rst mid-DRAIN discards queued entries. No sc_valid pulse survives reset.
- Wrap-around: pointers are modulo SQ_DEPTH; full when count==SQ_DEPTH, empty when count==0.

## Configuration
- REGFILE_BYPASS_EN defined: write-first. A read index equal to the active write target (nonzero) returns write_data in the same edge. Syscall v0/a0 sampling also sees the same-edge write.
- Undefined: read-first. Reads and syscall sampling return the pre-write contents; the pipeline must provide its own forwarding.

## Test plan
- Reset, then write rd=5←0xDEADBEEF; next cycle read rs=5 → read_data_1=0xDEADBEEF. Write rd=0←1, read rs=0 → 0.
- Same-edge write rd=7←0x55 and read rt=7 → 0x55 with REGFILE_BYPASS_EN, old value (0) without.
- sig_jal with rd=3, data 0x400 → regs[31]=0x400, regs[3] unchanged.
- v0=11, a0=0x141, syscall, sc_ready=1 → one entry {CHAR, 0x41}. v0=1, a0=−7 → {INT, 0xFFFFFFF9}.
- sc_ready=0, SQ_DEPTH+1 INT syscalls → stall high after 4th push, 5th not queued until one pop. Order preserved across pointer wrap.
- v0=10 syscall with 2 pending entries, sc_ready=1 → stall high, writes ignored, halt rises the edge after the 3rd pop. Asserting rst in DRAIN → all outputs 0, state RUN.
